// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Stall/flush sequencer for the 5-stage pipeline. It does the following:
//   - Detects load-use hazards that forwarding cannot cover.
//   - Freezes the pipe on I-cache and D-cache misses.
//   - Flushes the wrong path on a taken branch or jump.
//   - Parks the core once HALT reaches MEM/WB.
//   Control outputs are combinational from state and inputs. State and the
//   miss counter update on posedge clk.
//
// Parameters
//   MISS_TIMEOUT  cycles allowed in a miss state before timeout_err + HALT
//   CNT_W         miss counter width (2**CNT_W > MISS_TIMEOUT)
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   MemRead_IDEX, RegisterRd_IDEX   load in ID/EX and its destination
//   RegisterRs/Rt_IFID, Rs/RtUsed   source registers of the IF/ID instruction
//   Branch_taken_EX                 taken branch/jump resolved in EX
//   imem_stall/imem_done            I-cache miss in progress / fill complete
//   dmem_stall/dmem_done            D-cache miss in progress / access complete
//   Halt_MEMWB                      HALT has reached MEM/WB
//   pc_en..memwb_en                 stage register load enables
//   ifid_nop, idex_nop              inject a bubble into that stage register
//   halted, timeout_err             core parked / sticky miss timeout
//
// Optional feature: define STALL_PERF_CNT_EN to add the stall_cycles and
// bubbles saturating performance counters.
module pipe_hazard_ctrl #(
  parameter int MISS_TIMEOUT = 1023,
  parameter int CNT_W        = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       MemRead_IDEX,
  input  logic [2:0] RegisterRd_IDEX,
  input  logic [2:0] RegisterRs_IFID,
  input  logic [2:0] RegisterRt_IFID,
  input  logic       RsUsed_IFID,
  input  logic       RtUsed_IFID,
  input  logic       Branch_taken_EX,
  input  logic       imem_stall,
  input  logic       imem_done,
  input  logic       dmem_stall,
  input  logic       dmem_done,
  input  logic       Halt_MEMWB,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       ifid_nop,
  output logic       idex_nop,
  output logic       halted,
  output logic       timeout_err
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] bubbles
`endif
);

  typedef enum logic [1:0] {RUN, DMISS, IMISS, HALT} state_t;

  typedef struct packed {
    logic pcEn;
    logic ifidEn;
    logic idexEn;
    logic exmemEn;
    logic memwbEn;
    logic ifidNop;
    logic idexNop;
  } ctrl_t;

  localparam ctrl_t CTRL_GO     = 7'b11111_00;
  localparam ctrl_t CTRL_FREEZE = 7'b00000_00;
  localparam ctrl_t CTRL_FLUSH  = 7'b11111_11; // PC takes target, kill IF/ID + ID/EX
  localparam ctrl_t CTRL_IFILL  = 7'b01111_10; // no fetch word, back end drains
  localparam ctrl_t CTRL_LDUSE  = 7'b00111_01; // hold PC + IF/ID, one bubble
  localparam ctrl_t CTRL_RESET  = 7'b00000_11;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MISS_TIMEOUT);

  state_t           state, nextState, runNext;
  logic [CNT_W-1:0] cnt, nextCnt;
  ctrl_t            runCtrl, ctrl, ctrlOut;
  logic             loadUse, cntHit, setTo;

  // R0 is a real register here, so there is no Rd != 0 qualification.
  assign loadUse = MemRead_IDEX &
                   ((RsUsed_IFID & (RegisterRd_IDEX == RegisterRs_IFID)) |
                    (RtUsed_IFID & (RegisterRd_IDEX == RegisterRt_IFID)));
  assign cntHit  = (cnt == CNT_MAX);

  // Normal-flow priority list. It is shared by RUN and by the cycle in which
  // a D-miss completes. The D-miss entry term only applies from RUN, so a
  // lingering dmem_stall on the done cycle does not re-enter DMISS.
  always_comb begin : runRules
    runCtrl = CTRL_GO;
    runNext = RUN;
    if (Halt_MEMWB) begin
      runCtrl = CTRL_FREEZE;
      runNext = HALT;
    end else if (dmem_stall && state == RUN) begin
      runCtrl = CTRL_FREEZE;
      runNext = DMISS;
    end else if (Branch_taken_EX) begin
      runCtrl = CTRL_FLUSH;      // wrong-path fetch and load-use both moot
    end else if (imem_stall) begin
      runCtrl = CTRL_IFILL;
      runNext = IMISS;
    end else if (loadUse) begin
      runCtrl = CTRL_LDUSE;
    end
  end

  // Timeout is checked ahead of a coincident done pulse, so a miss that
  // reached the limit always parks the core.
  always_comb begin : nextLogic
    ctrl      = CTRL_FREEZE;
    nextState = state;
    nextCnt   = cnt;
    setTo     = 1'b0;
    unique case (state)
      RUN: begin
        ctrl      = runCtrl;
        nextState = runNext;
        nextCnt   = '0;
      end
      DMISS: begin
        if (cntHit) begin
          setTo     = 1'b1;
          nextState = HALT;
        end else if (dmem_done) begin
          ctrl      = runCtrl;
          nextState = runNext;
          nextCnt   = '0;
        end else begin
          nextCnt = cnt + CNT_W'(1);
        end
      end
      IMISS: begin
        if (cntHit) begin
          setTo     = 1'b1;
          nextState = HALT;
        end else if (Halt_MEMWB) begin
          nextState = HALT;
        end else if (dmem_stall) begin
          // The I-miss is re-detected from RUN later if still pending.
          nextState = DMISS;
          nextCnt   = '0;
        end else begin
          // Back end keeps advancing, so hazards downstream still apply.
          if (Branch_taken_EX)  ctrl = CTRL_FLUSH;
          else if (loadUse)     ctrl = CTRL_LDUSE;
          else if (imem_done)   ctrl = CTRL_GO;
          else                  ctrl = CTRL_IFILL;
          if (imem_done) begin
            nextState = RUN;
            nextCnt   = '0;
          end else begin
            nextCnt = cnt + CNT_W'(1);
          end
        end
      end
      default: ;                 // HALT: frozen until reset
    endcase
  end

  assign ctrlOut  = rst_n ? ctrl : CTRL_RESET;
  assign pc_en    = ctrlOut.pcEn;
  assign ifid_en  = ctrlOut.ifidEn;
  assign idex_en  = ctrlOut.idexEn;
  assign exmem_en = ctrlOut.exmemEn;
  assign memwb_en = ctrlOut.memwbEn;
  assign ifid_nop = ctrlOut.ifidNop;
  assign idex_nop = ctrlOut.idexNop;
  assign halted   = rst_n && (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
      if (setTo) timeout_err <= 1'b1;
    end
  end

`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      bubbles      <= '0;
    end else begin
      if (!ctrl.pcEn && state != HALT && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
      if (ctrl.idexNop && bubbles != 32'hFFFF_FFFF)
        bubbles <= bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl. It runs in three parts:
//   - A directed vector table.
//   - Hand-written multi-cycle sequences (timeout, reset mid-miss, perf counters).
//   - A randomized run against a cycle-level reference model of the
//     sequencer's rules.
module tb_pipe_hazard_ctrl;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       memRead, rsUsed, rtUsed, br, iStall, iDone, dStall, dDone, haltIn;
  logic [2:0] rd, rs, rt;
  logic       pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidNop, idexNop, halted, toErr;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stallCycles, bubbles;
`endif

  pipe_hazard_ctrl #(.MISS_TIMEOUT(TO), .CNT_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemRead_IDEX(memRead), .RegisterRd_IDEX(rd),
    .RegisterRs_IFID(rs), .RegisterRt_IFID(rt),
    .RsUsed_IFID(rsUsed), .RtUsed_IFID(rtUsed),
    .Branch_taken_EX(br),
    .imem_stall(iStall), .imem_done(iDone),
    .dmem_stall(dStall), .dmem_done(dDone),
    .Halt_MEMWB(haltIn),
    .pc_en(pcEn), .ifid_en(ifidEn), .idex_en(idexEn), .exmem_en(exmemEn),
    .memwb_en(memwbEn), .ifid_nop(ifidNop), .idex_nop(idexNop),
    .halted(halted), .timeout_err(toErr)
`ifdef STALL_PERF_CNT_EN
    , .stall_cycles(stallCycles), .bubbles(bubbles)
`endif
  );

  always #5 clk = ~clk;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_nop, idex_nop}
  localparam logic [6:0] GO  = 7'b1111100;
  localparam logic [6:0] FRZ = 7'b0000000;
  localparam logic [6:0] BR  = 7'b1111111;
  localparam logic [6:0] IM  = 7'b0111110;
  localparam logic [6:0] LU  = 7'b0011101;
  localparam logic [6:0] RST = 7'b0000011;

  wire [6:0] ctl = {pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidNop, idexNop};

  int vecs = 0;
  int errs = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_RUN = 0, M_DMISS = 1, M_IMISS = 2, M_HALT = 3;
  int          mMode, mCnt;
  bit          mTo;
  logic [31:0] mStall, mBub;

  function automatic void model(output logic [6:0] o, output logic h,
                                output int nMode, output int nCnt, output bit nTo);
    bit lu = memRead && ((rsUsed && rd == rs) || (rtUsed && rd == rt));
    bit normal = (mMode == M_RUN);
    o = FRZ; h = 1'b0; nMode = mMode; nCnt = mCnt; nTo = mTo;
    case (mMode)
      M_HALT:  h = 1'b1;
      M_DMISS: begin
        if (mCnt == TO) begin nTo = 1'b1; nMode = M_HALT; end
        else if (dDone) normal = 1'b1;
        else nCnt = mCnt + 1;
      end
      M_IMISS: begin
        if (mCnt == TO) begin nTo = 1'b1; nMode = M_HALT; end
        else if (haltIn) nMode = M_HALT;
        else if (dStall) begin nMode = M_DMISS; nCnt = 0; end
        else begin
          o = br ? BR : lu ? LU : iDone ? GO : IM;
          if (iDone) begin nMode = M_RUN; nCnt = 0; end
          else nCnt = mCnt + 1;
        end
      end
      default: ;
    endcase
    if (normal) begin
      nCnt = 0; nMode = M_RUN;
      if (haltIn) nMode = M_HALT;
      else if (dStall && mMode == M_RUN) nMode = M_DMISS;
      else if (br) o = BR;
      else if (iStall) begin o = IM; nMode = M_IMISS; end
      else o = lu ? LU : GO;
    end
  endfunction

  task automatic clearIns();
    memRead = 0; rd = 0; rs = 0; rt = 0; rsUsed = 0; rtUsed = 0;
    br = 0; iStall = 0; iDone = 0; dStall = 0; dDone = 0; haltIn = 0;
  endtask

  // Called at a negedge; compares before the next posedge and advances the model.
  task automatic step(input string name);
    logic [6:0] eo; logic eh; int nm, nc; bit nt;
    model(eo, eh, nm, nc, nt);
    #1;
    check(name, 64'({ctl, halted, toErr}), 64'({eo, eh, mTo}));
`ifdef STALL_PERF_CNT_EN
    check({name, "_perf"}, {stallCycles, bubbles}, {mStall, mBub});
    if (!eo[6] && mMode != M_HALT && mStall != 32'hFFFF_FFFF) mStall++;
    if (eo[0] && mBub != 32'hFFFF_FFFF) mBub++;
`endif
    mMode = nm; mCnt = nc; mTo = nt;
    @(negedge clk);
  endtask

  // Called at a negedge; the released cycle sees idle inputs in RUN (no change).
  task automatic doReset();
    clearIns();
    rst_n = 1'b0;
    #1;
    check("reset", 64'({ctl, halted, toErr}), 64'({RST, 2'b00}));
`ifdef STALL_PERF_CNT_EN
    check("reset_perf", {stallCycles, bubbles}, 64'd0);
`endif
    #2 rst_n = 1'b1;
    mMode = M_RUN; mCnt = 0; mTo = 1'b0; mStall = 0; mBub = 0;
    @(negedge clk);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       memRead, rsUsed, rtUsed, br, iStall, iDone, dStall, dDone, halt;
    logic [2:0] rd, rs, rt;
    logic [6:0] expCtl;
    logic       expHalted;
  } vec_t;

  function automatic vec_t mk(input int mr, input int d, input int s, input int t,
                              input int su, input int tu, input int b, input int is,
                              input int id, input int ds, input int dd, input int h,
                              input logic [6:0] e, input int eh);
    vec_t v;
    v.memRead = 1'(mr); v.rd = 3'(d); v.rs = 3'(s); v.rt = 3'(t);
    v.rsUsed = 1'(su); v.rtUsed = 1'(tu); v.br = 1'(b);
    v.iStall = 1'(is); v.iDone = 1'(id); v.dStall = 1'(ds); v.dDone = 1'(dd);
    v.halt = 1'(h); v.expCtl = e; v.expHalted = 1'(eh);
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int haltRun;
    logic [6:0] cSt;
    // mr rd rs rt su tu  br is id ds dd h   exp  halted
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0, GO, 0)); // idle
    tbl.push_back(mk(1,3,3,1,1,1, 0,0,0,0,0,0, LU, 0)); // LD R3 -> ADD Rs=R3
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0, GO, 0)); // one bubble only
    tbl.push_back(mk(1,3,1,3,1,0, 0,0,0,0,0,0, GO, 0)); // Rt match but unused
    tbl.push_back(mk(1,0,0,5,1,0, 0,0,0,0,0,0, LU, 0)); // R0 is a real register
    tbl.push_back(mk(1,5,2,5,0,1, 0,0,0,0,0,0, LU, 0)); // Rt path
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,1,0,0, FRZ, 0)); // D-miss 5 cycles
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,1,0, GO, 0)); // done cycle runs
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,1,0, GO, 0)); // stray done ignored
    tbl.push_back(mk(0,0,0,0,0,0, 1,1,0,0,0,0, BR, 0)); // branch beats I-miss
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0, GO, 0)); // stayed RUN
    tbl.push_back(mk(0,0,0,0,0,0, 0,1,0,0,0,0, IM, 0)); // enter IMISS
    tbl.push_back(mk(0,0,0,0,0,0, 0,1,0,0,0,0, IM, 0));
    tbl.push_back(mk(1,2,2,0,1,0, 0,1,0,0,0,0, LU, 0)); // load-use during I-miss
    tbl.push_back(mk(0,0,0,0,0,0, 1,1,0,0,0,0, BR, 0)); // branch during I-miss
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,1,0,0,0, GO, 0)); // fill done
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0, GO, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,1,0,0,0,0, IM, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,1,0,1,0,0, FRZ, 0)); // D-miss preempts I-miss
    tbl.push_back(mk(0,0,0,0,0,0, 0,1,0,0,1,0, IM, 0)); // I-miss re-entered
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,1,0,0,0, GO, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 1,0,0,1,0,0, FRZ, 0)); // D-miss beats branch
    tbl.push_back(mk(0,0,0,0,0,0, 1,0,0,0,1,0, BR, 0)); // branch on done cycle
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,1,0,0,0, GO, 0)); // stray imem_done
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,1,0,1, FRZ, 0)); // halt beats D-miss
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0, FRZ, 1));
    tbl.push_back(mk(1,1,1,1,1,1, 1,0,0,0,1,0, FRZ, 1)); // HALT ignores all

    clearIns();
    rst_n = 1'b0;
    mMode = M_RUN; mCnt = 0; mTo = 1'b0; mStall = 0; mBub = 0;
    #2;
    check("reset_init", 64'({ctl, halted, toErr}), 64'({RST, 2'b00}));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      memRead = tbl[i].memRead; rd = tbl[i].rd; rs = tbl[i].rs; rt = tbl[i].rt;
      rsUsed = tbl[i].rsUsed; rtUsed = tbl[i].rtUsed; br = tbl[i].br;
      iStall = tbl[i].iStall; iDone = tbl[i].iDone; dStall = tbl[i].dStall;
      dDone = tbl[i].dDone; haltIn = tbl[i].halt;
      #1;
      check($sformatf("dir%0d", i), 64'({ctl, halted, toErr}),
            64'({tbl[i].expCtl, tbl[i].expHalted, 1'b0}));
      @(negedge clk);
    end

    // Miss timeout: D-miss held until the counter hits MISS_TIMEOUT.
    doReset();
    dStall = 1'b1;
    repeat (TO + 2) step("timeout");
    #1;
    check("timeout_halt", 64'({halted, toErr}), 64'(2'b11));
    @(negedge clk);
    dStall = 1'b0;
    repeat (3) step("timeout_park");

    // Reset pulsed in the middle of a D-miss.
    doReset();
    dStall = 1'b1;
    repeat (3) step("dmiss_pre");
    doReset();
    step("after_reset");

`ifdef STALL_PERF_CNT_EN
    // One load-use bubble plus a 5-cycle D-miss.
    doReset();
    memRead = 1; rd = 3; rs = 3; rsUsed = 1;
    step("perf_lu");
    clearIns();
    dStall = 1'b1;
    repeat (5) step("perf_dmiss");
    dStall = 1'b0; dDone = 1'b1;
    step("perf_done");
    dDone = 1'b0;
    #1;
    cSt = 7'd0;
    check("perf_totals", {stallCycles, bubbles}, {32'd6, 32'd1});
    @(negedge clk);
`endif

    // Randomized run against the model.
    doReset();
    haltRun = 0;
    for (int n = 0; n < 3000; n++) begin
      memRead = ($urandom_range(0, 1) == 0);
      rd = 3'($urandom_range(0, 3));
      rs = 3'($urandom_range(0, 3));
      rt = 3'($urandom_range(0, 3));
      rsUsed = ($urandom_range(0, 1) == 0);
      rtUsed = ($urandom_range(0, 1) == 0);
      br     = ($urandom_range(0, 7) == 0);
      iStall = ($urandom_range(0, 4) == 0);
      iDone  = ($urandom_range(0, 5) == 0);
      dStall = ($urandom_range(0, 7) == 0);
      dDone  = ($urandom_range(0, 4) == 0);
      haltIn = ($urandom_range(0, 99) == 0);
      step("rand");
      haltRun = (mMode == M_HALT) ? haltRun + 1 : 0;
      if (haltRun >= 3) begin
        doReset();
        haltRun = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
